// File: rtl/drum_sched_pkg.sv
// Shared types and helpers for the DRUM multiplier sharing scheduler.
package drum_sched_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DRUM_N    = 16;
  localparam int unsigned DRUM_R    = 4;
  localparam int unsigned DRUM_ID_W = clog2_min1(DRUM_R);

  typedef struct packed {
    logic [DRUM_N-1:0]    a;
    logic [DRUM_N-1:0]    b;
    logic [DRUM_ID_W-1:0] id;
  } drum_op_t;

  typedef struct packed {
    logic [2*DRUM_N-1:0]  r;
    logic [DRUM_ID_W-1:0] id;
  } drum_rsp_t;

endpackage

// File: rtl/DRUMs.sv
// Signed DRUM multiplier: sign-magnitude wrapper around the unsigned core.
module DRUMs #(
  parameter int unsigned N = 16,
  parameter int unsigned K = 6
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] r_o
);

  logic [N-1:0]   am_c;
  logic [N-1:0]   bm_c;
  logic [2*N-1:0] rm_c;
  logic           neg_c;

  // The most negative value maps to 2^(N-1), still representable unsigned.
  assign am_c  = a_i[N-1] ? (-a_i) : a_i;
  assign bm_c  = b_i[N-1] ? (-b_i) : b_i;
  assign neg_c = a_i[N-1] ^ b_i[N-1];

  DRUMu #(.N(N), .K(K)) u_mag (
    .a_i (am_c),
    .b_i (bm_c),
    .r_o (rm_c)
  );

  assign r_o = neg_c ? (-rm_c) : rm_c;

endmodule

// File: rtl/DRUMu.sv
// Unsigned DRUM multiplier: each operand is cut to the K bits starting at its
// leading one with the LSB forced high, multiplied, then shifted back.
module DRUMu #(
  parameter int unsigned N = 16,
  parameter int unsigned K = 6
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] r_o
);

  localparam int unsigned SW = $clog2(N);

  logic [K-1:0]  ma_c;
  logic [K-1:0]  mb_c;
  logic [SW-1:0] sa_c;
  logic [SW-1:0] sb_c;

  // Highest set bit at or above K wins; smaller operands pass through exactly.
  always_comb begin
    ma_c = a_i[K-1:0];
    mb_c = b_i[K-1:0];
    sa_c = '0;
    sb_c = '0;
    for (int unsigned i = K; i < N; i++) begin
      if (a_i[i]) begin
        ma_c = {a_i[i -: (K-1)], 1'b1};
        sa_c = SW'(i - K + 1);
      end
      if (b_i[i]) begin
        mb_c = {b_i[i -: (K-1)], 1'b1};
        sb_c = SW'(i - K + 1);
      end
    end
    r_o = ((2*N)'(ma_c) * (2*N)'(mb_c)) << ({1'b0, sa_c} + {1'b0, sb_c});
  end

endmodule

// File: rtl/drum_rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or after ptr wins.
module drum_rr_arbiter
  import drum_sched_pkg::*;
#(
  parameter int unsigned R = 4,
  localparam int unsigned IDW = clog2_min1(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic [IDW-1:0] idx_c;
  logic           found_c;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned off = 0; off < R; off++) begin
      idx_c = IDW'((32'(ptr) + off) % R);
      if (!found_c && req[idx_c]) begin
        found_c      = 1'b1;
        gnt_idx      = idx_c;
        gnt[idx_c]   = en;
      end
    end
  end

endmodule

// File: rtl/drum_share_sched.sv
// Shares one DRUM approximate multiplier among R valid/ready requesters through
// an operand stage and a result stage, granting round-robin.
module drum_share_sched
  import drum_sched_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned K      = 6,
  parameter int unsigned R      = 4,
  parameter bit          SIGNED = 1'b0,
  localparam int unsigned IDW   = clog2_min1(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*N-1:0] rsp_r,
  output logic [IDW-1:0] rsp_id,
  output logic           busy
);

  logic           v0_q, v0_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [IDW-1:0] id0_q, id0_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [2*N-1:0] rsp_r_q, rsp_r_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic           adv0_c, adv1_c, xfer_c;
  logic [R-1:0]   gnt_c;
  logic [IDW-1:0] gnt_idx_c;
  logic [2*N-1:0] core_r_c;
  logic [N-1:0]   a_arr [R];
  logic [N-1:0]   b_arr [R];

  for (genvar i = 0; i < R; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*N +: N];
    assign b_arr[i] = req_b[i*N +: N];
  end

  assign adv1_c = !rsp_valid_q || rsp_ready;
  assign adv0_c = !v0_q || adv1_c;

  // No grant is offered while reset is asserted.
  drum_rr_arbiter #(.R(R)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (adv0_c && !rst),
    .gnt     (gnt_c),
    .gnt_idx (gnt_idx_c)
  );

  assign req_ready = gnt_c;
  assign xfer_c    = |(gnt_c & req_valid);

  if (SIGNED) begin : g_core_s
    DRUMs #(.N(N), .K(K)) u_core (.a_i(a_q), .b_i(b_q), .r_o(core_r_c));
  end else begin : g_core_u
    DRUMu #(.N(N), .K(K)) u_core (.a_i(a_q), .b_i(b_q), .r_o(core_r_c));
  end

  always_comb begin
    v0_d        = v0_q;
    a_d         = a_q;
    b_d         = b_q;
    id0_d       = id0_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_r_d     = rsp_r_q;
    rsp_id_d    = rsp_id_q;
    if (adv0_c) begin
      v0_d = xfer_c;
      if (xfer_c) begin
        a_d   = a_arr[gnt_idx_c];
        b_d   = b_arr[gnt_idx_c];
        id0_d = gnt_idx_c;
        ptr_d = (gnt_idx_c == IDW'(R-1)) ? '0 : gnt_idx_c + IDW'(1);
      end
    end
    if (adv1_c) begin
      rsp_valid_d = v0_q;
      rsp_r_d     = core_r_c;
      rsp_id_d    = id0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      id0_q       <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_r_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      v0_q        <= v0_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id0_q       <= id0_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_r_q     <= rsp_r_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = v0_q | rsp_valid_q;

endmodule

// File: tb/tb_drum_share_sched.sv
// Bench for drum_share_sched: directed products, round-robin order, back-pressure
// and reset, with an in-order scoreboard on the unsigned instance.
module tb_drum_share_sched;
  import drum_sched_pkg::*;

  localparam int unsigned N = 16;
  localparam int unsigned K = 6;
  localparam int unsigned R = 4;

  localparam int unsigned EX_ID [5] = '{2, 0, 1, 3, 1};
  localparam logic [15:0] EX_A  [5] = '{16'd3, 16'd1000, 16'd0, 16'd63, 16'hFFFF};
  localparam logic [15:0] EX_B  [5] = '{16'd5, 16'd1000, 16'd12345, 16'd63, 16'hFFFF};
  localparam logic [31:0] EX_R  [5] = '{32'd15, 32'd1016064, 32'd0, 32'd3969, 32'hF8100000};

  localparam int unsigned SG_ID [3] = '{1, 2, 3};
  localparam logic [15:0] SG_A  [3] = '{16'hFFFD, 16'h8000, 16'hFFFB};
  localparam logic [15:0] SG_B  [3] = '{16'd7, 16'd1, 16'hFFFB};
  localparam logic [31:0] SG_R  [3] = '{32'hFFFFFFEB, 32'hFFFF7C00, 32'd25};

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req_valid, req_ready;
  logic [R*N-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [2*N-1:0] rsp_r;
  logic [1:0]     rsp_id;
  logic           busy;

  logic [R-1:0]   s_req_valid, s_req_ready;
  logic [R*N-1:0] s_req_a, s_req_b;
  logic           s_rsp_valid, s_rsp_ready;
  logic [2*N-1:0] s_rsp_r;
  logic [1:0]     s_rsp_id;
  logic           s_busy;

  int n_tests = 0;
  int n_fail  = 0;
  drum_rsp_t sb_q[$];

  always #5 clk = ~clk;

  drum_share_sched #(.N(N), .K(K), .R(R), .SIGNED(1'b0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_id(rsp_id), .busy(busy));

  drum_share_sched #(.N(N), .K(K), .R(R), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_a(s_req_a), .req_b(s_req_b), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_r(s_rsp_r), .rsp_id(s_rsp_id), .busy(s_busy));

  // Reference unsigned DRUM: halve until below 2^K, then force the LSB.
  function automatic logic [31:0] drum_model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] ta, tb_;
    int unsigned sa, sb;
    ta = a; tb_ = b; sa = 0; sb = 0;
    while (ta >= 16'd64) begin ta = ta >> 1; sa++; end
    while (tb_ >= 16'd64) begin tb_ = tb_ >> 1; sb++; end
    if (sa > 0) ta = ta | 16'd1;
    if (sb > 0) tb_ = tb_ | 16'd1;
    return (32'(ta) * 32'(tb_)) << (sa + sb);
  endfunction

  // Scoreboard: expectation pushed on each accept, popped on each delivered response.
  always @(negedge clk) begin
    drum_rsp_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got r=%0h id=%0d, required no response", rsp_r, rsp_id);
        end else begin
          e = sb_q.pop_front();
          if (rsp_r !== e.r || rsp_id !== e.id) begin
            n_fail++;
            $display("FAIL sb_data: got r=%0h id=%0d, required r=%0h id=%0d", rsp_r, rsp_id, e.r, e.id);
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.r  = drum_model(req_a[i*16 +: 16], req_b[i*16 +: 16]);
          e.id = 2'(i);
          sb_q.push_back(e);
        end
      end
    end
  end

  task automatic new_ops(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        req_a[i*16 +: 16] = 16'($urandom) >> $urandom_range(0, 15);
        req_b[i*16 +: 16] = 16'($urandom) >> $urandom_range(0, 15);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rsp_ready = 1'b1; req_valid = '1; req_a = '0; req_b = '0;
    s_rsp_ready = 1'b1; s_req_valid = '1; s_req_a = '0; s_req_b = '0;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ready: got %b, required 0000", req_ready);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; s_req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_r !== 32'd0 || rsp_id !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%0h id=%0d busy=%b, required 0 0 0 0", rsp_valid, rsp_r, rsp_id, busy);
    end
    n_tests++;
    if (s_rsp_valid !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_signed: got v=%b busy=%b, required 0 0", s_rsp_valid, s_busy);
    end
  endtask

  task automatic test_products;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      req_a[EX_ID[e]*16 +: 16] = EX_A[e];
      req_b[EX_ID[e]*16 +: 16] = EX_B[e];
      req_valid = 4'(1 << EX_ID[e]);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'(1 << EX_ID[e])) begin
        n_fail++; $display("FAIL prod%0d_grant: got %b, required %b", e, req_ready, 4'(1 << EX_ID[e]));
      end
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_r !== EX_R[e] || rsp_id !== 2'(EX_ID[e])) begin
        n_fail++;
        $display("FAIL prod%0d: got v=%b r=%0d id=%0d, required v=1 r=%0d id=%0d", e, rsp_valid, rsp_r, rsp_id, EX_R[e], EX_ID[e]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL prod_idle: got v=%b busy=%b, required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_signed;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      s_req_a[SG_ID[e]*16 +: 16] = SG_A[e];
      s_req_b[SG_ID[e]*16 +: 16] = SG_B[e];
      s_req_valid = 4'(1 << SG_ID[e]);
      @(posedge clk); #1;
      s_req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (s_rsp_valid !== 1'b1 || s_rsp_r !== SG_R[e] || s_rsp_id !== 2'(SG_ID[e])) begin
        n_fail++;
        $display("FAIL signed%0d: got v=%b r=%0h id=%0d, required v=1 r=%0h id=%0d", e, s_rsp_valid, s_rsp_r, s_rsp_id, SG_R[e], SG_ID[e]);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] xm;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1; req_valid = '1; new_ops(4'hF);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b, required %b", k, req_ready, 4'(1 << (k % 4)));
      end
      if (k >= 2) begin
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(k - 2)) begin
          n_fail++; $display("FAIL rr_rsp%0d: got v=%b id=%0d, required v=1 id=%0d", k, rsp_valid, rsp_id, (k - 2) % 4);
        end
      end
      xm = req_valid & req_ready;
      @(posedge clk); #1;
      new_ops(xm);
    end
    req_valid = '0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (!busy) break; end
    n_tests++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL rr_drain: got busy=%b pending=%0d, required 0 0", busy, sb_q.size());
    end
  endtask

  task automatic test_back_pressure;
    logic [3:0]  xm;
    logic [31:0] hold_r;
    logic [1:0]  hold_id;
    int          acc;
    acc = 0; hold_r = '0; hold_id = '0;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = '1; new_ops(4'hF);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      xm = req_valid & req_ready;
      acc += $countones(xm);
      if (c >= 3) begin
        n_tests++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
          n_fail++; $display("FAIL bp_full%0d: got ready=%b v=%b, required 0000 1", c, req_ready, rsp_valid);
        end
      end
      if (c == 3) begin
        hold_r = rsp_r; hold_id = rsp_id;
      end else if (c > 3) begin
        n_tests++;
        if (rsp_r !== hold_r || rsp_id !== hold_id) begin
          n_fail++; $display("FAIL bp_hold%0d: got r=%0h id=%0d, required r=%0h id=%0d", c, rsp_r, rsp_id, hold_r, hold_id);
        end
      end
      @(posedge clk); #1;
      new_ops(xm);
    end
    n_tests++;
    if (acc != 2) begin
      n_fail++; $display("FAIL bp_accepts: got %0d, required 2", acc);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_tests++;
        if ($countones(req_ready) != 1 || rsp_valid !== 1'b1) begin
          n_fail++; $display("FAIL bp_release: got ready=%b v=%b, required one-hot 1", req_ready, rsp_valid);
        end
      end
      xm = req_valid & req_ready;
      @(posedge clk); #1;
      new_ops(xm);
    end
    req_valid = '0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (!busy) break; end
    n_tests++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL bp_drain: got busy=%b pending=%0d, required 0 0", busy, sb_q.size());
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 4'b0110; new_ops(4'b0110);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; req_valid = '1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_full: got busy=%b ready=%b, required 1 0000", busy, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_after: got v=%b busy=%b ready=%b, required 0 0 0001", rsp_valid, busy, req_ready);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; req_valid = '0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (!busy) break; end
    n_tests++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_drain: got busy=%b pending=%0d, required 0 0", busy, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_signed();
    test_round_robin();
    test_back_pressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
